// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the frame-buffer DDR arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef logic [1:0] bank_t;

    localparam int unsigned STAT_W      = 16;
    localparam bank_t       WR_BANK_RST = 2'd0;
    localparam bank_t       RD_BANK_RST = 2'd1;

    // Third bank of the triple buffer: the one neither argument is using.
    function automatic bank_t next_free_bank(input bank_t committed, input bank_t rd);
        bank_t b;
        if (committed != 2'd0 && rd != 2'd0) begin
            b = 2'd0;
        end else if (committed != 2'd1 && rd != 2'd1) begin
            b = 2'd1;
        end else begin
            b = 2'd2;
        end
        return b;
    endfunction

endpackage

// File: rtl/fb_bank_mgr.sv
// Triple-buffer bank bookkeeping: pending vsyncs, frame commit/drop, display bank.
// Optional FB_ARB_STATS_EN adds dropped-frame and repeated-frame counters.
module fb_bank_mgr
    import fb_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_vsync_i,
    input  logic        rd_vsync_i,
    input  logic        idle_i,
    input  logic        wr_frame_full_i,
    output logic [1:0]  wr_bank_o,
    output logic [1:0]  rd_bank_o,
    output logic        wr_pend_o,
    output logic        rd_pend_o
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0] wr_drop_cnt_o,
    output logic [15:0] rd_repeat_cnt_o
`endif
);

    bank_t wr_bank_q, wr_bank_d;
    bank_t rd_bank_q, rd_bank_d;
    bank_t committed_q, committed_d;
    logic  wr_pend_q, wr_pend_d;
    logic  rd_pend_q, rd_pend_d;
    logic  apply;
    logic  wr_drop;
    logic  rd_repeat;

    // Pending flags are only consumed while no burst is outstanding.
    assign apply = idle_i && (wr_pend_q || rd_pend_q);

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        committed_d = committed_q;
        wr_pend_d   = wr_pend_q | wr_vsync_i;
        rd_pend_d   = rd_pend_q | rd_vsync_i;
        wr_drop     = 1'b0;
        rd_repeat   = 1'b0;
        if (apply) begin
            wr_pend_d = wr_vsync_i;
            rd_pend_d = rd_vsync_i;
            if (wr_pend_q) begin
                if (wr_frame_full_i) begin
                    committed_d = wr_bank_q;
                    wr_bank_d   = next_free_bank(wr_bank_q, rd_bank_q);
                end else begin
                    wr_drop = 1'b1;
                end
            end
            // Read side sees the commit made in the same cycle.
            if (rd_pend_q) begin
                rd_repeat = (committed_d == rd_bank_q);
                rd_bank_d = committed_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= WR_BANK_RST;
            rd_bank_q   <= RD_BANK_RST;
            committed_q <= RD_BANK_RST;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            committed_q <= committed_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign wr_bank_o = wr_bank_q;
    assign rd_bank_o = rd_bank_q;
    assign wr_pend_o = wr_pend_q;
    assign rd_pend_o = rd_pend_q;

`ifdef FB_ARB_STATS_EN
    logic [STAT_W-1:0] drop_q, drop_d;
    logic [STAT_W-1:0] rep_q, rep_d;

    // Saturating event counters.
    always_comb begin
        drop_d = drop_q;
        rep_d  = rep_q;
        if (wr_drop && drop_q != {STAT_W{1'b1}}) begin
            drop_d = drop_q + STAT_W'(1);
        end
        if (rd_repeat && rep_q != {STAT_W{1'b1}}) begin
            rep_d = rep_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            rep_q  <= '0;
        end else begin
            drop_q <= drop_d;
            rep_q  <= rep_d;
        end
    end

    assign wr_drop_cnt_o   = drop_q;
    assign rd_repeat_cnt_o = rep_q;
`endif

endmodule

// File: rtl/fb_ddr_arb.sv
// DDR user-port arbiter between the vin frame writer and vout frame reader.
// Optional FB_ARB_STATS_EN exposes dropped/repeated frame counters.
module fb_ddr_arb
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 28,
    parameter int unsigned BURST_LEN    = 64,
    parameter int unsigned FRAME_BURSTS = 14400,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned BANK_STRIDE  = 'h0100000,
    parameter int unsigned FIFO_AW      = 10,
    parameter int unsigned WR_URGENT    = 768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vsync,
    input  logic                  rd_vsync,
    input  logic [FIFO_AW-1:0]    wr_fifo_level,
    input  logic [FIFO_AW-1:0]    rd_fifo_free,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_is_wr,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  xfer_done,
    output logic [1:0]            wr_bank,
    output logic [1:0]            rd_bank,
    output logic                  busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]           wr_drop_cnt,
    output logic [15:0]           rd_repeat_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FRAME_BURSTS + 1);

    arb_state_e            state_q, state_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_is_wr_q, cmd_is_wr_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;

    logic                  wr_pend, rd_pend;
    logic                  wr_req, rd_req, pick_wr;
    logic [1:0]            sel_bank;
    logic [CNT_W-1:0]      sel_cnt;
    logic [ADDR_WIDTH-1:0] next_addr;

    fb_bank_mgr u_bank_mgr (
        .clk             (clk),
        .rst             (rst),
        .wr_vsync_i      (wr_vsync),
        .rd_vsync_i      (rd_vsync),
        .idle_i          (state_q == ST_IDLE),
        .wr_frame_full_i (32'(wr_cnt_q) == FRAME_BURSTS),
        .wr_bank_o       (wr_bank),
        .rd_bank_o       (rd_bank),
        .wr_pend_o       (wr_pend),
        .rd_pend_o       (rd_pend)
`ifdef FB_ARB_STATS_EN
        ,
        .wr_drop_cnt_o   (wr_drop_cnt),
        .rd_repeat_cnt_o (rd_repeat_cnt)
`endif
    );

    assign wr_req  = (32'(wr_fifo_level) >= BURST_LEN) && (32'(wr_cnt_q) < FRAME_BURSTS);
    assign rd_req  = (32'(rd_fifo_free) >= BURST_LEN) && (32'(rd_cnt_q) < FRAME_BURSTS);
    // A nearly full vin FIFO overrides the display's default priority.
    assign pick_wr = wr_req && ((32'(wr_fifo_level) >= WR_URGENT) || !rd_req);

    assign sel_bank  = pick_wr ? wr_bank : rd_bank;
    assign sel_cnt   = pick_wr ? wr_cnt_q : rd_cnt_q;
    assign next_addr = ADDR_WIDTH'(BASE_ADDR)
                     + ADDR_WIDTH'(sel_bank) * ADDR_WIDTH'(BANK_STRIDE)
                     + ADDR_WIDTH'(sel_cnt) * ADDR_WIDTH'(BURST_LEN);

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_is_wr_d = cmd_is_wr_q;
        cmd_addr_d  = cmd_addr_q;
        busy_d      = busy_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // A vsync cycle only updates banks; requests are judged afterwards.
                if (wr_pend || rd_pend) begin
                    if (wr_pend) wr_cnt_d = '0;
                    if (rd_pend) rd_cnt_d = '0;
                end else if (wr_req || rd_req) begin
                    cmd_valid_d = 1'b1;
                    cmd_is_wr_d = pick_wr;
                    cmd_addr_d  = next_addr;
                    state_d     = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (xfer_done) begin
                    if (cmd_is_wr_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    else             rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_is_wr_q <= 1'b0;
            cmd_addr_q  <= '0;
            busy_q      <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_is_wr_q <= cmd_is_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            busy_q      <= busy_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_is_wr = cmd_is_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fb_ddr_arb.sv
// Self-checking bench for fb_ddr_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_fb_ddr_arb;

    localparam int unsigned AW   = 28;
    localparam int unsigned BL   = 8;
    localparam int unsigned FB   = 4;
    localparam int unsigned BASE = 0;
    localparam int unsigned STR  = 'h100;
    localparam int unsigned FAW  = 10;
    localparam int unsigned URG  = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_vsync = 1'b0, rd_vsync = 1'b0;
    logic [FAW-1:0] wr_fifo_level = '0, rd_fifo_free = '0;
    logic           cmd_ready = 1'b0, xfer_done = 1'b0;
    logic           cmd_valid, cmd_is_wr, busy;
    logic [AW-1:0]  cmd_addr;
    logic [1:0]     wr_bank, rd_bank;
`ifdef FB_ARB_STATS_EN
    logic [15:0]    wr_drop_cnt, rd_repeat_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    fb_ddr_arb #(
        .ADDR_WIDTH(AW), .BURST_LEN(BL), .FRAME_BURSTS(FB), .BASE_ADDR(BASE),
        .BANK_STRIDE(STR), .FIFO_AW(FAW), .WR_URGENT(URG)
    ) dut (
        .clk(clk), .rst(rst), .wr_vsync(wr_vsync), .rd_vsync(rd_vsync),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_free(rd_fifo_free),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
        .cmd_addr(cmd_addr), .xfer_done(xfer_done), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .busy(busy)
`ifdef FB_ARB_STATS_EN
        , .wr_drop_cnt(wr_drop_cnt), .rd_repeat_cnt(rd_repeat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = command offered, 2 = data phase.
    int m_phase, m_wb, m_rb, m_cb, m_wc, m_rc, m_drop, m_rep, m_addr;
    bit m_valid, m_wr, m_busy, m_wp, m_rp, m_live = 0;
    bit mw_req, mr_req, m_pick;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_valid = 0; m_wr = 0; m_addr = 0; m_busy = 0;
            m_wb = 0; m_rb = 1; m_cb = 1; m_wc = 0; m_rc = 0;
            m_wp = 0; m_rp = 0; m_drop = 0; m_rep = 0; m_live = 1;
        end else begin
            case (m_phase)
                0: begin
                    if (m_wp || m_rp) begin
                        if (m_wp) begin
                            if (m_wc == FB) begin
                                m_cb = m_wb;
                                m_wb = 3 - m_cb - m_rb;
                            end else if (m_drop < 'hFFFF) begin
                                m_drop++;
                            end
                            m_wc = 0;
                        end
                        if (m_rp) begin
                            if (m_cb == m_rb && m_rep < 'hFFFF) m_rep++;
                            m_rb = m_cb;
                            m_rc = 0;
                        end
                        m_wp = 0; m_rp = 0;
                    end else begin
                        mw_req = (int'(wr_fifo_level) >= BL) && (m_wc < FB);
                        mr_req = (int'(rd_fifo_free) >= BL) && (m_rc < FB);
                        if (mw_req || mr_req) begin
                            m_pick  = mw_req && ((int'(wr_fifo_level) >= URG) || !mr_req);
                            m_valid = 1;
                            m_wr    = m_pick;
                            m_addr  = (BASE + (m_pick ? m_wb : m_rb) * STR
                                       + (m_pick ? m_wc : m_rc) * BL) % (1 << AW);
                            m_phase = 1;
                        end
                    end
                end
                1: if (cmd_ready) begin m_valid = 0; m_busy = 1; m_phase = 2; end
                default: if (xfer_done) begin
                    if (m_wr) m_wc++; else m_rc++;
                    m_busy = 0; m_phase = 0;
                end
            endcase
            if (wr_vsync) m_wp = 1;
            if (rd_vsync) m_rp = 1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
            chk("cmd_is_wr", 32'(cmd_is_wr), 32'(m_wr));
            chk("cmd_addr",  32'(cmd_addr),  32'(m_addr));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("wr_bank",   32'(wr_bank),   32'(m_wb));
            chk("rd_bank",   32'(rd_bank),   32'(m_rb));
            chk("bank_clash", 32'(wr_bank != rd_bank), 32'd1);
`ifdef FB_ARB_STATS_EN
            chk("wr_drop_cnt",   32'(wr_drop_cnt),   32'(m_drop));
            chk("rd_repeat_cnt", 32'(rd_repeat_cnt), 32'(m_rep));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_vsync = 0; rd_vsync = 0; cmd_ready = 0; xfer_done = 0;
        wr_fifo_level = '0; rd_fifo_free = '0;
        cyc(); cyc();
        rst = 0;
    endtask

    // One full burst from a free arbiter: offer, accept, complete.
    task automatic burst(input string nm, input bit exp_wr, input int exp_addr);
        cmd_ready = 1;
        cyc();
        chk({nm, ".valid"}, 32'(cmd_valid), 32'd1);
        chk({nm, ".is_wr"}, 32'(cmd_is_wr), 32'(exp_wr));
        chk({nm, ".addr"},  32'(cmd_addr),  32'(exp_addr));
        cyc();
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        cmd_ready = 0; xfer_done = 1;
        cyc();
        xfer_done = 0;
        chk({nm, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_vsync(input bit w, input bit r);
        wr_vsync = w; rd_vsync = r;
        cyc();
        wr_vsync = 0; rd_vsync = 0;
        cyc();
    endtask

    initial begin
        do_reset();
        chk("rst.valid", 32'(cmd_valid), 32'd0);
        chk("rst.wr_bank", 32'(wr_bank), 32'd0);
        chk("rst.rd_bank", 32'(rd_bank), 32'd1);

        // Lone write, then the next write advances by one burst.
        wr_fifo_level = 8;
        burst("s1.w0", 1, 'h000);
        burst("s1.w1", 1, 'h008);

        // Read wins by default; urgent write level overrides it.
        do_reset();
        wr_fifo_level = 8; rd_fifo_free = 8;
        burst("s2.rd", 0, 'h100);
        wr_fifo_level = 40;
        burst("s2.urg", 1, 'h000);

        // Complete frame, commit, then display it.
        do_reset();
        wr_fifo_level = 8;
        burst("s3.w0", 1, 'h000);
        burst("s3.w1", 1, 'h008);
        burst("s3.w2", 1, 'h010);
        burst("s3.w3", 1, 'h018);
        cyc();
        chk("s3.full_noreq", 32'(cmd_valid), 32'd0);
        wr_fifo_level = 0;
        pulse_vsync(1, 0);
        chk("s3.wr_bank", 32'(wr_bank), 32'd2);
        chk("s3.rd_bank_hold", 32'(rd_bank), 32'd1);
        pulse_vsync(0, 1);
        chk("s3.rd_bank", 32'(rd_bank), 32'd0);
        rd_fifo_free = 8;
        burst("s3.rd0", 0, 'h000);

        // Incomplete frame is dropped.
        do_reset();
        wr_fifo_level = 8;
        burst("s4.w0", 1, 'h000);
        burst("s4.w1", 1, 'h008);
        wr_fifo_level = 0;
        pulse_vsync(1, 0);
        chk("s4.wr_bank", 32'(wr_bank), 32'd0);
`ifdef FB_ARB_STATS_EN
        chk("s4.drop_cnt", 32'(wr_drop_cnt), 32'd1);
`endif
        wr_fifo_level = 8;
        burst("s4.w_restart", 1, 'h000);

        // vsync during the data phase waits for completion.
        do_reset();
        wr_fifo_level = 8;
        burst("s5.w0", 1, 'h000);
        burst("s5.w1", 1, 'h008);
        burst("s5.w2", 1, 'h010);
        cmd_ready = 1;
        cyc(); cyc();
        cmd_ready = 0; wr_fifo_level = 0; wr_vsync = 1;
        cyc();
        wr_vsync = 0;
        cyc();
        chk("s5.wait_bank", 32'(wr_bank), 32'd0);
        xfer_done = 1;
        cyc();
        xfer_done = 0;
        chk("s5.done_bank", 32'(wr_bank), 32'd0);
        cyc();
        chk("s5.commit_bank", 32'(wr_bank), 32'd2);

        // Both vsyncs together after a complete frame.
        do_reset();
        wr_fifo_level = 8;
        for (int i = 0; i < 4; i++) burst("s5b.w", 1, i * 8);
        wr_fifo_level = 0;
        pulse_vsync(1, 1);
        chk("s5b.wr_bank", 32'(wr_bank), 32'd2);
        chk("s5b.rd_bank", 32'(rd_bank), 32'd0);

        // Back-pressure holds the command, then reset mid-burst.
        do_reset();
        wr_fifo_level = 8;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("s6.hold_valid", 32'(cmd_valid), 32'd1);
            chk("s6.hold_wr",    32'(cmd_is_wr), 32'd1);
            chk("s6.hold_addr",  32'(cmd_addr),  32'h000);
        end
        cmd_ready = 1;
        cyc();
        cmd_ready = 0;
        chk("s6.busy", 32'(busy), 32'd1);
        rst = 1;
        cyc();
        rst = 0; wr_fifo_level = 0;
        chk("s6.rst_valid", 32'(cmd_valid), 32'd0);
        chk("s6.rst_busy",  32'(busy),      32'd0);
        chk("s6.rst_addr",  32'(cmd_addr),  32'd0);
        xfer_done = 1;
        cyc();
        xfer_done = 0;
        chk("s6.ignored_done", 32'(busy), 32'd0);
        wr_fifo_level = 8;
        cyc();
        chk("s6.addr_after", 32'(cmd_addr), 32'h000);
        chk("s6.valid_after", 32'(cmd_valid), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wr_fifo_level = FAW'($urandom_range(0, 48));
            rd_fifo_free  = FAW'($urandom_range(0, 16));
            cmd_ready     = ($urandom_range(0, 9) < 6);
            xfer_done     = ($urandom_range(0, 9) < 4);
            wr_vsync      = ($urandom_range(0, 99) < 3);
            rd_vsync      = ($urandom_range(0, 99) < 3);
            rst           = ($urandom_range(0, 999) < 3);
            cyc();
        end
        rst = 0; wr_vsync = 0; rd_vsync = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
